// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode stage: req/ack fetch into the IR, field split, and
// a valid/ready hand-off of the decoded instruction to execute.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | one cycle after reset, no request, nothing issued
// FETCH | mem_req high at mem_addr=pc, waiting for mem_ack
// ISSUE | decoded instruction offered to execute, waiting for ready
module instr_fetch_decode #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic [3:0]  rdest,
  output logic [3:0]  op_ext,
  output logic [3:0]  rsrc,
  output logic [7:0]  imm8,
  output logic        sign_extend,
  output logic        is_imm,
  output logic        issue_valid,
  input  logic        issue_ready,
  input  logic        pc_load,
  input  logic [15:0] pc_target
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [15:0] pcReg;
  logic [15:0] irReg;
  logic        isImmReg;
  logic        signExtReg;
  logic        fetchDone;
  logic        issueDone;

  function automatic logic decodeIsImm(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0010, 4'b0011, 4'b0101,
      4'b1001, 4'b1011, 4'b1100, 4'b1101, 4'b1111: decodeIsImm = 1'b1;
      default:                                     decodeIsImm = 1'b0;
    endcase
  endfunction

  // Logical immediates and LUI are zero-extended; arithmetic, compare,
  // branch displacement and MOVI are sign-extended.
  function automatic logic decodeSignExt(input logic [3:0] op);
    case (op)
      4'b0101, 4'b1001, 4'b1011, 4'b1100, 4'b1101: decodeSignExt = 1'b1;
      default:                                     decodeSignExt = 1'b0;
    endcase
  endfunction

  assign fetchDone = (state == FETCH) && mem_ack;
  assign issueDone = (state == ISSUE) && issue_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pcReg      <= RESET_PC;
      irReg      <= 16'h0000;
      isImmReg   <= 1'b0;
      signExtReg <= 1'b0;
    end else begin
      state <= stateNext;
      if (fetchDone) begin
        irReg      <= mem_rdata;
        isImmReg   <= decodeIsImm(mem_rdata[15:12]);
        signExtReg <= decodeSignExt(mem_rdata[15:12]);
        pcReg      <= pcReg + 16'd1;
      end else if (issueDone && pc_load) begin
        pcReg <= pc_target;
      end
    end
  end

  // Request/valid decode straight from state so reset drops them at once.
  always_comb begin
    stateNext   = state;
    mem_req     = 1'b0;
    issue_valid = 1'b0;
    case (state)
      IDLE: stateNext = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) stateNext = ISSUE;
      end
      ISSUE: begin
        issue_valid = 1'b1;
        if (issue_ready) stateNext = FETCH;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign pc          = pcReg;
  assign mem_addr    = pcReg;
  assign ir          = irReg;
  assign opcode      = irReg[15:12];
  assign rdest       = irReg[11:8];
  assign op_ext      = irReg[7:4];
  assign rsrc        = irReg[3:0];
  assign imm8        = irReg[7:0];
  assign is_imm      = isImmReg;
  assign sign_extend = signExtReg;

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Instruction fetch and decode stage of the 16-bit datapath. It sequences a request/acknowledge fetch from instruction memory and latches the word into the instruction register. It splits the word into register and opcode fields, and drives the 8-bit immediate plus its extension control directly into the immediate sign extender. Decoded fields are held stable for the execute stage until that stage accepts them with a valid/ready handshake.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  16  fetch address; always equals pc.
- mem_ack  in  1  memory acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  16  fetched instruction word.
- pc  out  16  current program counter.
- ir  out  16  latched instruction word.
- opcode  out  4  ir[15:12].
- rdest  out  4  ir[11:8].
- op_ext  out  4  ir[7:4].
- rsrc  out  4  ir[3:0].
- imm8  out  8  ir[7:0]; drives the sign extender data input.
- sign_extend  out  1  drives the sign extender control input.
- is_imm  out  1  instruction uses imm8 as the second operand.
- issue_valid  out  1  decoded instruction is available to execute.
- issue_ready  in  1  execute accepts the decoded instruction.
- pc_load  in  1  redirect request (branch/jump taken).
- pc_target  in  16  redirect address.

## Operation
- The FSM has three states: IDLE, FETCH and ISSUE. Reset forces IDLE.
- IDLE: mem_req=0, issue_valid=0. The FSM always moves to FETCH on the next edge.
- FETCH: mem_req=1 and mem_addr=pc, both held stable until mem_ack.
  - On an edge with mem_ack=1: ir<=mem_rdata, decode registers load from mem_rdata, pc<=pc+1 (mod 2^16, so 16'hFFFF wraps to 16'h0000), and the FSM moves to ISSUE.
- ISSUE: issue_valid=1. ir, the decoded fields and pc are held stable.
  - On an edge with issue_ready=1: if pc_load=1 then pc<=pc_target, otherwise pc is unchanged. The FSM moves to FETCH.
- Decode rules:
  - is_imm=1 for opcode values 0001, 0010, 0011, 0101, 1001, 1011, 1100, 1101 and 1111. It is 0 otherwise (0000 register class, 0100 load/store/jump class, all others).
  - sign_extend=1 for opcode values 0101 (ADDI), 1001 (SUBI), 1011 (CMPI), 1100 (Bcond displacement) and 1101 (MOVI).
  - sign_extend=0 for 0001, 0010 and 0011 (ANDI, ORI, XORI; zero-extended), for 1111 (LUI), and for all non-immediate opcodes.
- pc_load is honoured only on the ISSUE handshake edge. It is ignored in IDLE, in FETCH, and in ISSUE while issue_ready=0.
- mem_ack and mem_rdata are ignored outside FETCH.
- issue_ready is ignored outside ISSUE.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, ir=16'h0000, all decoded fields 0, sign_extend=0, is_imm=0, mem_req=0, issue_valid=0.
- Asserting reset in any state, including mid-fetch or mid-issue, clears mem_req and issue_valid immediately, without waiting for a clock edge.
- First mem_req: one cycle after reset deasserts (the IDLE cycle).
- Fetch latency: decoded outputs and issue_valid update on the same edge that samples mem_ack=1.
- Minimum instruction period is 2 cycles: FETCH with an immediate mem_ack, then ISSUE with issue_ready already high.
- The FSM never passes through IDLE again after reset.
- The sign extender is combinational, so the 16-bit immediate is valid in the same cycle as issue_valid.
- mem_req and issue_valid are never high in the same cycle.

## Test plan
- Reset and idle behaviour: hold reset, then release with RESET_PC=16'h0010.
  - Required: mem_req=0 during reset and during the first cycle after release; mem_req=1 with mem_addr=16'h0010 on the second cycle.
- Back-to-back fetch: memory acks every request immediately, issue_ready tied high, words 16'h5A85 then 16'h1AFF.
  - Required for the first word: ADDI, rdest=4'hA, imm8=8'h85, sign_extend=1, is_imm=1.
  - Required for the second word: ANDI, sign_extend=0, is_imm=1.
  - Required overall: pc steps 0, 1, 2, and each instruction takes 2 cycles.
- Memory and execute stalls: mem_ack delayed 3 cycles, then issue_ready held low 4 cycles.
  - Required: mem_addr stable for the whole wait; ir, fields and pc stable while issue_valid=1 and issue_ready=0; no second fetch until the handshake completes.
- Redirect: pc_load=1 with pc_target=16'h0200, applied once during FETCH and once on the ISSUE handshake.
  - Required: the FETCH-cycle request is ignored; the handshake request makes the next mem_addr 16'h0200.
- Wrap and register-class decode: start with pc=16'hFFFF and fetch 16'h0153.
  - Required: pc becomes 16'h0000; is_imm=0, sign_extend=0, rdest=4'h1, op_ext=4'h5, rsrc=4'h3.
- Mid-operation reset: assert reset while in FETCH with mem_req=1, and again while in ISSUE.
  - Required: mem_req and issue_valid fall immediately, pc=RESET_PC, and the fetch restarts from RESET_PC after release.
